// File: rtl/hazard_unit_v2.sv
// hazard_unit_v2: decode-side hazard controller for the in-order RISC-V pipeline.
// Combines load-use stalling (configurable bubble depth), in-flight branch
// tracking with configurable resolve latency, a global freeze input, perf
// counters and a sticky protocol-error flag.
//
// Handshake / timing contract: all control outputs are combinational for the
// current cycle. A branch is tracked from the cycle it leaves ID; the execute
// logic must assert br_resolve_valid exactly BR_LAT cycles later (frozen cycles
// excluded). A valid with nothing due, or a due branch with no valid, is a
// protocol error; the missing resolution is treated as not-taken.
module hazard_unit_v2 #(
   parameter int REG_W          = 5,
   parameter int OPC_W          = 7,
   parameter int LOAD_STALL_CYC = 1,
   parameter int BR_LAT         = 1,
   parameter int JALR_IS_BR     = 1,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_ex_mem_read,
   input  logic [REG_W-1:0]  id_ex_rd,
   input  logic [REG_W-1:0]  if_id_rs1,
   input  logic [REG_W-1:0]  if_id_rs2,
   input  logic              if_id_use_rs1,
   input  logic              if_id_use_rs2,
   input  logic [OPC_W-1:0]  id_opcode,
   input  logic              br_resolve_valid,
   input  logic              br_taken,
   input  logic              ext_stall,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_write,
   output logic              ex_mem_write,
   output logic              control_on,
   output logic [BR_LAT-1:0] flush_vec,
   output logic              br_pending,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              proto_err
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LSTALL = 1'b1
   } state_t;

   localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(7'b1101111);
   localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(7'b1100011);
   localparam logic [OPC_W-1:0] OP_JALR   = OPC_W'(7'b1100111);
   // Remaining bubbles after the first one, loaded when entering LSTALL.
   localparam logic [1:0]       LSC_INIT  = 2'(LOAD_STALL_CYC - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_cnt;
   logic [1:0]         w_cnt_nxt;
   logic [BR_LAT-1:0]  r_br_pipe;
   logic [BR_LAT-1:0]  w_br_pipe_nxt;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;
   logic               r_proto_err;

   logic w_haz;
   logic w_is_br;
   logic w_resolve;
   logic w_taken_flush;
   logic w_lu_req;
   logic w_stall;
   logic w_br_in;
   logic w_proto_evt;

   // Load-use hazard; x0 never carries a real dependency.
   assign w_haz = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                   (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

   assign w_is_br = (id_opcode == OP_JAL) || (id_opcode == OP_BRANCH) ||
                    ((JALR_IS_BR != 0) && (id_opcode == OP_JALR));

   // Oldest tracked branch is due this cycle.
   assign w_resolve     = r_br_pipe[BR_LAT-1];
   // A freeze defers the resolution: the pipe holds, so it is re-presented later.
   assign w_taken_flush = w_resolve && br_resolve_valid && br_taken && !ext_stall;
   assign w_lu_req      = (r_state == ST_LSTALL) || w_haz;
   // Effective stall after priority: freeze and taken flush both win over it.
   assign w_stall       = w_lu_req && !w_taken_flush && !ext_stall;
   // Only a branch that actually leaves ID this cycle enters the tracker.
   assign w_br_in       = w_is_br && !w_stall && !w_taken_flush;
   // Valid without a due branch, or a due branch without valid.
   assign w_proto_evt   = !ext_stall && (w_resolve != br_resolve_valid);

   // FSM state and bubble-count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next state: freeze holds, taken flush aborts any stall.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!ext_stall) begin
         if (w_taken_flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 2'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_haz && (LOAD_STALL_CYC > 1)) begin
                     w_state_nxt = ST_LSTALL;
                     w_cnt_nxt   = LSC_INIT;
                  end
               end
               ST_LSTALL: begin
                  if (r_cnt <= 2'd1) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = 2'd0;
                  end else begin
                     w_cnt_nxt = r_cnt - 2'd1;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 2'd0;
               end
            endcase
         end
      end
   end

   // FSM outputs: pipeline enables, bubble select and flush lines by priority.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      control_on   = 1'b1;
      flush_vec    = '0;
      if (rst) begin
         flush_vec = '0;
      end else if (ext_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (w_taken_flush) begin
         flush_vec = '1;
      end else if (w_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         control_on  = 1'b0;
      end
   end

   // Branch tracker next value: shift unless frozen, clear on a taken flush.
   always_comb begin
      w_br_pipe_nxt = r_br_pipe;
      if (!ext_stall) begin
         if (w_taken_flush) begin
            w_br_pipe_nxt = '0;
         end else begin
            for (int i = BR_LAT - 1; i > 0; i--) begin
               w_br_pipe_nxt[i] = r_br_pipe[i-1];
            end
            w_br_pipe_nxt[0] = w_br_in;
         end
      end
   end

   // Branch tracker register.
   always_ff @(posedge clk) begin
      if (rst) r_br_pipe <= '0;
      else     r_br_pipe <= w_br_pipe_nxt;
   end

   // Saturating perf counters and the sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_taken_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if (w_proto_evt) r_proto_err <= 1'b1;
      end
   end

   assign br_pending = |r_br_pipe;
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed bench for hazard_unit_v2 with LOAD_STALL_CYC=2 and BR_LAT=2.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_unit_v2;
   localparam int REG_W = 5;
   localparam int OPC_W = 7;
   localparam int LSC   = 2;
   localparam int BRL   = 2;
   localparam int CNT_W = 16;

   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ADD  = 7'b0110011;

   // {pc_write, if_id_write, id_ex_write, ex_mem_write, control_on}
   localparam logic [4:0] EN_RUN   = 5'b11111;
   localparam logic [4:0] EN_STALL = 5'b00110;
   localparam logic [4:0] EN_FRZ   = 5'b00001;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_ex_mem_read;
   logic [REG_W-1:0] id_ex_rd, if_id_rs1, if_id_rs2;
   logic             if_id_use_rs1, if_id_use_rs2;
   logic [OPC_W-1:0] id_opcode;
   logic             br_resolve_valid, br_taken, ext_stall;
   logic             pc_write, if_id_write, id_ex_write, ex_mem_write, control_on;
   logic [BRL-1:0]   flush_vec;
   logic             br_pending;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             proto_err;
   logic [4:0]       en;

   int checks = 0;
   int errors = 0;

   assign en = {pc_write, if_id_write, id_ex_write, ex_mem_write, control_on};

   hazard_unit_v2 #(
      .REG_W(REG_W), .OPC_W(OPC_W), .LOAD_STALL_CYC(LSC), .BR_LAT(BRL),
      .JALR_IS_BR(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .if_id_use_rs1(if_id_use_rs1), .if_id_use_rs2(if_id_use_rs2),
      .id_opcode(id_opcode),
      .br_resolve_valid(br_resolve_valid), .br_taken(br_taken),
      .ext_stall(ext_stall),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
      .control_on(control_on), .flush_vec(flush_vec),
      .br_pending(br_pending), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .proto_err(proto_err)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic drive_idle();
      id_ex_mem_read   = 1'b0;
      id_ex_rd         = '0;
      if_id_rs1        = '0;
      if_id_rs2        = '0;
      if_id_use_rs1    = 1'b0;
      if_id_use_rs2    = 1'b0;
      id_opcode        = OP_ADD;
      br_resolve_valid = 1'b0;
      br_taken         = 1'b0;
      ext_stall        = 1'b0;
   endtask

   task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic u1, input logic [4:0] rs2, input logic u2);
      id_ex_mem_read = 1'b1;
      id_ex_rd       = rd;
      if_id_rs1      = rs1;
      if_id_use_rs1  = u1;
      if_id_rs2      = rs2;
      if_id_use_rs2  = u2;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      ext_stall = 1'b1;
      br_resolve_valid = 1'b1;
      #1;
      checks++;
      if (en !== EN_RUN || flush_vec !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: en=%b flush=%b required en=%b flush=00", en, flush_vec, EN_RUN);
      end
      @(negedge clk);
      #1;
      checks++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || proto_err !== 1'b0 || br_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: stall_cnt=%0d flush_cnt=%0d proto_err=%b br_pending=%b required 0 0 0 0",
                  stall_cnt, flush_cnt, proto_err, br_pending);
      end
      rst = 1'b0;
      drive_idle();
   endtask

   task automatic test_load_use();
      apply_reset();
      drive_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      #1;
      checks++;
      if (en !== EN_STALL) begin
         errors++;
         $display("FAIL lu_stall_1: en=%b required %b", en, EN_STALL);
      end
      // load has moved on; the second bubble must come from the stall state
      @(negedge clk);
      id_ex_mem_read = 1'b0;
      #1;
      checks++;
      if (en !== EN_STALL) begin
         errors++;
         $display("FAIL lu_stall_2: en=%b required %b", en, EN_STALL);
      end
      @(negedge clk);
      #1;
      checks++;
      if (en !== EN_RUN || stall_cnt !== 16'd2) begin
         errors++;
         $display("FAIL lu_release: en=%b stall_cnt=%0d required en=%b stall_cnt=2", en, stall_cnt, EN_RUN);
      end
   endtask

   task automatic test_operand_use();
      // rd matches rs1 but rs1 unused, rs2 differs -> no hazard
      @(negedge clk);
      drive_load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
      #1;
      checks++;
      if (en !== EN_RUN) begin
         errors++;
         $display("FAIL unused_rs1: en=%b required %b", en, EN_RUN);
      end
      // rs2 dependency stalls
      @(negedge clk);
      if_id_rs2 = 5'd7;
      #1;
      checks++;
      if (en !== EN_STALL) begin
         errors++;
         $display("FAIL rs2_hazard: en=%b required %b", en, EN_STALL);
      end
      @(negedge clk);
      id_ex_mem_read = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (en !== EN_RUN || stall_cnt !== 16'd4) begin
         errors++;
         $display("FAIL rs2_release: en=%b stall_cnt=%0d required en=%b stall_cnt=4", en, stall_cnt, EN_RUN);
      end
   endtask

   task automatic test_x0();
      apply_reset();
      drive_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      #1;
      checks++;
      if (en !== EN_RUN) begin
         errors++;
         $display("FAIL x0_no_stall: en=%b required %b", en, EN_RUN);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL x0_stall_cnt: stall_cnt=%0d required 0", stall_cnt);
      end
   endtask

   task automatic test_branch_taken();
      apply_reset();
      id_opcode = OP_BEQ;
      #1;
      checks++;
      if (br_pending !== 1'b0) begin
         errors++;
         $display("FAIL br_pending_before: br_pending=%b required 0", br_pending);
      end
      @(negedge clk);
      id_opcode = OP_ADD;
      #1;
      checks++;
      if (br_pending !== 1'b1 || flush_vec !== 2'b00) begin
         errors++;
         $display("FAIL br_in_flight: br_pending=%b flush=%b required 1 00", br_pending, flush_vec);
      end
      @(negedge clk);
      br_resolve_valid = 1'b1;
      br_taken = 1'b1;
      #1;
      checks++;
      if (flush_vec !== 2'b11 || en !== EN_RUN) begin
         errors++;
         $display("FAIL br_flush: flush=%b en=%b required 11 %b", flush_vec, en, EN_RUN);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (flush_vec !== 2'b00 || br_pending !== 1'b0 || flush_cnt !== 16'd1 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL br_after: flush=%b pending=%b flush_cnt=%0d proto_err=%b required 00 0 1 0",
                  flush_vec, br_pending, flush_cnt, proto_err);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      id_opcode = OP_BEQ;
      @(negedge clk);
      id_opcode = OP_JAL;
      @(negedge clk);
      id_opcode = OP_ADD;
      br_resolve_valid = 1'b1;
      br_taken = 1'b1;
      // simultaneous load-use hazard loses to the flush
      drive_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      #1;
      checks++;
      if (flush_vec !== 2'b11 || en !== EN_RUN) begin
         errors++;
         $display("FAIL b2b_flush_over_stall: flush=%b en=%b required 11 %b", flush_vec, en, EN_RUN);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (br_pending !== 1'b0 || flush_vec !== 2'b00) begin
         errors++;
         $display("FAIL b2b_squash: br_pending=%b flush=%b required 0 00", br_pending, flush_vec);
      end
      @(negedge clk);
      #1;
      checks++;
      if (proto_err !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL b2b_counts: proto_err=%b flush_cnt=%0d stall_cnt=%0d required 0 1 0",
                  proto_err, flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_not_taken();
      apply_reset();
      id_opcode = OP_BEQ;
      @(negedge clk);
      id_opcode = OP_ADD;
      @(negedge clk);
      br_resolve_valid = 1'b1;
      br_taken = 1'b0;
      #1;
      checks++;
      if (flush_vec !== 2'b00 || en !== EN_RUN) begin
         errors++;
         $display("FAIL nt_no_flush: flush=%b en=%b required 00 %b", flush_vec, en, EN_RUN);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (br_pending !== 1'b0 || flush_cnt !== 16'd0 || proto_err !== 1'b0) begin
         errors++;
         $display("FAIL nt_after: pending=%b flush_cnt=%0d proto_err=%b required 0 0 0",
                  br_pending, flush_cnt, proto_err);
      end
   endtask

   task automatic test_missing_resolve();
      apply_reset();
      id_opcode = OP_JALR;
      @(negedge clk);
      id_opcode = OP_ADD;
      @(negedge clk);
      br_taken = 1'b1;
      #1;
      checks++;
      if (flush_vec !== 2'b00) begin
         errors++;
         $display("FAIL missing_no_flush: flush=%b required 00", flush_vec);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (proto_err !== 1'b1 || br_pending !== 1'b0 || flush_cnt !== 16'd0) begin
         errors++;
         $display("FAIL missing_proto: proto_err=%b pending=%b flush_cnt=%0d required 1 0 0",
                  proto_err, br_pending, flush_cnt);
      end
   endtask

   task automatic test_ext_stall_lstall();
      apply_reset();
      drive_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      #1;
      checks++;
      if (en !== EN_STALL) begin
         errors++;
         $display("FAIL frz_first_stall: en=%b required %b", en, EN_STALL);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         id_ex_mem_read = 1'b0;
         ext_stall = 1'b1;
         #1;
         checks++;
         if (en !== EN_FRZ || flush_vec !== 2'b00 || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL frz_hold[%0d]: en=%b flush=%b stall_cnt=%0d required %b 00 1",
                     i, en, flush_vec, stall_cnt, EN_FRZ);
         end
      end
      @(negedge clk);
      ext_stall = 1'b0;
      #1;
      checks++;
      if (en !== EN_STALL) begin
         errors++;
         $display("FAIL frz_resume: en=%b required %b", en, EN_STALL);
      end
      @(negedge clk);
      #1;
      checks++;
      if (en !== EN_RUN || stall_cnt !== 16'd2) begin
         errors++;
         $display("FAIL frz_done: en=%b stall_cnt=%0d required %b 2", en, stall_cnt, EN_RUN);
      end
   endtask

   task automatic test_ext_stall_flush();
      apply_reset();
      id_opcode = OP_BEQ;
      @(negedge clk);
      id_opcode = OP_ADD;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         ext_stall = 1'b1;
         br_resolve_valid = 1'b1;
         br_taken = 1'b1;
         #1;
         checks++;
         if (flush_vec !== 2'b00 || en !== EN_FRZ || br_pending !== 1'b1) begin
            errors++;
            $display("FAIL frz_defer[%0d]: flush=%b en=%b pending=%b required 00 %b 1",
                     i, flush_vec, en, br_pending, EN_FRZ);
         end
      end
      @(negedge clk);
      ext_stall = 1'b0;
      #1;
      checks++;
      if (flush_vec !== 2'b11) begin
         errors++;
         $display("FAIL frz_deferred_flush: flush=%b required 11", flush_vec);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (flush_cnt !== 16'd1 || proto_err !== 1'b0 || br_pending !== 1'b0) begin
         errors++;
         $display("FAIL frz_flush_after: flush_cnt=%0d proto_err=%b pending=%b required 1 0 0",
                  flush_cnt, proto_err, br_pending);
      end
   endtask

   task automatic test_proto_err();
      apply_reset();
      br_resolve_valid = 1'b1;
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("FAIL proto_set: proto_err=%b required 1", proto_err);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (proto_err !== 1'b1) begin
         errors++;
         $display("FAIL proto_sticky: proto_err=%b required 1", proto_err);
      end
      apply_reset();
      #1;
      checks++;
      if (proto_err !== 1'b0) begin
         errors++;
         $display("FAIL proto_cleared: proto_err=%b required 0", proto_err);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_load_use();
      test_operand_use();
      test_x0();
      test_branch_taken();
      test_back_to_back();
      test_not_taken();
      test_missing_resolve();
      test_ext_stall_lstall();
      test_ext_stall_flush();
      test_proto_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Backstop so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_unit_v2.md
Name: hazard_unit_v2

Overview:
- Parametrised hazard controller for the in-order RISC-V pipeline; the next generation of the existing load-use/branch hazard detector.
- Sits beside the decode stage. Drives the PC, IF/ID, ID/EX and EX/MEM write enables, the control-bubble select, and per-stage flush lines.
- Adds four things the current detector lacks:
  - configurable load-use stall depth;
  - configurable branch resolve latency, with in-flight branch tracking;
  - external global stall;
  - x0/operand-use qualification, saturating performance counters and a protocol-error flag.

Parameters:
- REG_W, 5, register-address width.
- OPC_W, 7, opcode width.
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (1..3).
- BR_LAT, 1, cycles from a branch leaving ID to its resolution (1..3).
- JALR_IS_BR, 1, treat opcode 1100111 as a control transfer.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_ex_mem_read  in  1  instruction in ID/EX is a load
- id_ex_rd  in  REG_W  destination of ID/EX instruction
- if_id_rs1  in  REG_W  source 1 of decoding instruction
- if_id_rs2  in  REG_W  source 2 of decoding instruction
- if_id_use_rs1  in  1  decoding instruction reads rs1
- if_id_use_rs2  in  1  decoding instruction reads rs2
- id_opcode  in  OPC_W  opcode in ID
- br_resolve_valid  in  1  execute logic resolves a branch this cycle
- br_taken  in  1  resolved branch redirects (valid with br_resolve_valid)
- ext_stall  in  1  global freeze (memory busy)
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID enable
- id_ex_write  out  1  ID/EX enable
- ex_mem_write  out  1  EX/MEM enable
- control_on  out  1  0 = inject bubble into ID/EX
- flush_vec  out  BR_LAT  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM
- br_pending  out  1  any branch in flight
- stall_cnt  out  CNT_W  load-use bubble cycles, saturating
- flush_cnt  out  CNT_W  taken-branch flush events, saturating
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, stall counter 0, br_pipe 0, both perf counters 0, proto_err 0. While rst=1, outputs are forced to pc_write=if_id_write=id_ex_write=ex_mem_write=control_on=1 and flush_vec=0. Reset mid-stall or mid-branch aborts everything.
- Hazard condition haz = id_ex_mem_read & id_ex_rd!=0 & ((use_rs1 & rd==rs1) | (use_rs2 & rd==rs2)). No stall when rd is x0.
- FSM states:
  - IDLE: haz=1 → stall this cycle, combinationally. If LOAD_STALL_CYC>1, go to LSTALL with cnt=LOAD_STALL_CYC-1.
  - LSTALL: stall; cnt decrements each cycle. At cnt=1 the next state is IDLE.
- Stall cycle outputs: pc_write=0, if_id_write=0, control_on=0; id_ex_write and ex_mem_write stay 1. stall_cnt increments once per stall cycle.
- Branch tracking with br_pipe[BR_LAT-1:0] shift register. It shifts on every cycle with ext_stall=0.
  - Bit0 input = 1 when id_opcode ∈ {1101111, 1100011, 1100111 if JALR_IS_BR} and the ID instruction advances (no stall, no flush). Otherwise 0.
  - br_pending = |br_pipe.
- Resolution happens when br_pipe[BR_LAT-1]=1:
  - If br_resolve_valid=0: set proto_err (sticky) and treat the branch as not-taken.
  - If br_taken=1: flush_vec = all ones for 1 cycle, flush_cnt++, br_pipe cleared (younger branches squashed), FSM forced to IDLE, pc_write=1.
  - A taken flush overrides a simultaneous load-use stall.
- br_resolve_valid=1 with br_pipe[BR_LAT-1]=0 also sets proto_err.
- ext_stall=1 freezes everything:
  - all four write enables 0, control_on 1, flush_vec 0;
  - FSM, cnt, br_pipe and perf counters hold.
  - ext_stall takes priority over a flush: the resolution is deferred until ext_stall drops.
- Priority: rst > ext_stall > taken flush > load-use stall > normal.
- Perf counters saturate at all-ones and never wrap.

Test Plan:
- LOAD_STALL_CYC=2; load x5 then add using rs1=x5 → pc_write/if_id_write/control_on=0 for exactly 2 cycles; stall_cnt=2.
- Load to x0 followed by a reader of x0 → no stall; stall_cnt stays 0.
- BR_LAT=2; beq in ID, then two cycles later br_resolve_valid=1, br_taken=1 → flush_vec=2'b11 for 1 cycle; flush_cnt=1; br_pending=0 next cycle.
- BR_LAT=2; two back-to-back branches, first taken → second squashed; no proto_err; flush_cnt=1.
- ext_stall=1 for 3 cycles during an LSTALL → all enables 0; cnt holds; stall resumes and completes after release; stall_cnt unchanged during the freeze.
- br_resolve_valid pulsed with no branch in flight → proto_err=1 and stays 1 until rst.
